mfe_seq: RTL and testbench
==========================

MFE_SEQ -- requirements
Module: mfe_seq

Interface
REQ-001 SHALL have parameter WORD_W, 64, SPI/operand word width.
REQ-002 SHALL have parameter KEY_WORDS, 64, encrypted key words (even, >=2).
REQ-003 SHALL have parameter AES_LAT, 38, AES input-to-output latency in cycles (>=1).
REQ-004 SHALL have parameter OP_WORDS, 32, words per n, r, t and message; also result word count.
REQ-005 SHALL have parameter NP_WORDS, 2, nprime0 words.
REQ-006 SHALL have port clk in 1, sole clock.
REQ-007 SHALL have port rst in 1, reset; asynchronous, active-high.
REQ-008 SHALL have ports start in 1 (begin session), next in 1 (next message), abort in 1 (cancel session).
REQ-009 SHALL have ports spi_valid in 1 and spi_data in WORD_W, the inbound word stream.
REQ-010 SHALL have port spi_sel out 3, source select: 0 NONE, 1 KEY, 2 NRT, 3 MSG, 4 RESULT.
REQ-011 SHALL have ports aes_in out 2*WORD_W, aes_in_valid out 1 and aes_out in 2*WORD_W.
REQ-012 SHALL have ports mx_data out 2*WORD_W, mx_valid out 1 and mx_seg out 3 (0 E, 1 N, 2 R, 3 T, 4 NP, 5 M).
REQ-013 SHALL have ports mx_start out 1, mx_done in 1, mx_res_valid in 1 and mx_res in 2*WORD_W.
REQ-014 SHALL have ports out_valid out 1, out_data out 2*WORD_W, busy out 1, err out 1 and state_dbg out 4.

Function
REQ-015 SHALL have states IDLE(0), LOAD_KEY(1), DECRYPT(2), DRAIN(3), LOAD_OPS(4), LOAD_MSG(5), COMPUTE(6), SEND(7) and WAIT_NEXT(8); state_dbg SHALL equal the current state.
REQ-016 IDLE: start=1 SHALL go to LOAD_KEY with spi_sel=KEY and err cleared; start in any other state SHALL be ignored.
REQ-017 LOAD_KEY: each spi_valid word SHALL be stored at key_buf[count]; after KEY_WORDS words SHALL go to DECRYPT with spi_sel=NONE.
REQ-018 DECRYPT: SHALL issue one block per cycle, aes_in={key_buf[2i],key_buf[2i+1]} with aes_in_valid=1, for i=0..KEY_WORDS/2-1, then go to DRAIN.
REQ-019 An AES_LAT-deep valid shift register SHALL mark aes_out sampling; each marked aes_out SHALL appear next cycle on mx_data with mx_seg=E and mx_valid=1.
REQ-020 DRAIN: after KEY_WORDS/2 results are forwarded, SHALL go to LOAD_OPS with spi_sel=NRT.
REQ-021 LOAD_OPS: SHALL forward each accepted word one cycle later, zero-extended on mx_data, tagged N, R, T (OP_WORDS each) then NP (NP_WORDS); after the last word SHALL go to LOAD_MSG with spi_sel=MSG.
REQ-022 LOAD_MSG: SHALL forward OP_WORDS words tagged M, then pulse mx_start for 1 cycle, set spi_sel=NONE and go to COMPUTE.
REQ-023 COMPUTE: mx_done=1 SHALL go to SEND with spi_sel=RESULT.
REQ-024 SEND: each mx_res_valid word SHALL appear next cycle on out_data with out_valid=1; after OP_WORDS words SHALL go to WAIT_NEXT with spi_sel=NONE.
REQ-025 WAIT_NEXT: next=1 SHALL go to LOAD_MSG with spi_sel=MSG; key and operands are retained downstream and not reloaded.
REQ-026 spi_valid outside LOAD_KEY/LOAD_OPS/LOAD_MSG, and mx_res_valid outside SEND, SHALL be ignored; extra words SHALL never overrun any counter.
REQ-027 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, set err, and drop all outputs to reset values; abort SHALL win over simultaneous start/next.
REQ-028 busy SHALL be 1 in every state except IDLE and WAIT_NEXT.

Reset
REQ-029 rst SHALL asynchronously force IDLE, all counters 0, key_buf cleared, all outputs 0, spi_sel=NONE, err=0, including mid-operation.
REQ-030 The first state change after rst deasserts SHALL require a new start.

Configuration
REQ-031 With MFE_SEQ_TIMEOUT_EN defined, a 16-bit idle counter SHALL abort to IDLE with err=1 when LOAD_KEY, LOAD_OPS, LOAD_MSG, COMPUTE or SEND sees 65535 consecutive cycles without progress; without it, the block SHALL wait indefinitely.

Verification (WORD_W=8, KEY_WORDS=4, AES_LAT=3, OP_WORDS=2, NP_WORDS=1)
REQ-032 start, key 11,22,33,44 -> aes_in 1122 then 3344 on consecutive cycles; stubbed aes_out AAAA,BBBB -> mx_data AAAA,BBBB with seg E.
REQ-033 Operands 01..07 -> mx_seg N,N,R,R,T,T,NP; message 08,09 -> seg M,M, then one mx_start pulse.
REQ-034 mx_done, then mx_res 5555,6666 -> out_data 5555,6666; WAIT_NEXT, then next -> LOAD_MSG with spi_sel=3.
REQ-035 abort together with next in WAIT_NEXT -> IDLE, err=1; rst asserted during DECRYPT -> immediate IDLE, all outputs 0.
REQ-036 spi_valid pulses during DECRYPT and a fifth key word -> ignored, and the key count stays at 4.

Source files
------------

// File: rtl/mfe_seq.sv
// rtl/mfe_seq.sv - modular-exponentiation front-end sequencer: key load/decrypt, operand/message streaming, result return
// Optional build macro: MFE_SEQ_TIMEOUT_EN (stall watchdog aborts to IDLE with err set).
module mfe_seq #(
    parameter int WORD_W    = 64,
    parameter int KEY_WORDS = 64,
    parameter int AES_LAT   = 38,
    parameter int OP_WORDS  = 32,
    parameter int NP_WORDS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  next,
    input  logic                  abort,
    input  logic                  spi_valid,
    input  logic [WORD_W-1:0]     spi_data,
    output logic [2:0]            spi_sel,
    output logic [2*WORD_W-1:0]   aes_in,
    output logic                  aes_in_valid,
    input  logic [2*WORD_W-1:0]   aes_out,
    output logic [2*WORD_W-1:0]   mx_data,
    output logic                  mx_valid,
    output logic [2:0]            mx_seg,
    output logic                  mx_start,
    input  logic                  mx_done,
    input  logic                  mx_res_valid,
    input  logic [2*WORD_W-1:0]   mx_res,
    output logic                  out_valid,
    output logic [2*WORD_W-1:0]   out_data,
    output logic                  busy,
    output logic                  err,
    output logic [3:0]            state_dbg
);
    localparam int BLOCKS    = KEY_WORDS / 2;
    localparam int OPS_TOTAL = 3 * OP_WORDS + NP_WORDS;
    localparam int CNT_W     = $clog2(KEY_WORDS + OPS_TOTAL + 1);
    localparam int KI_W      = $clog2(KEY_WORDS);

    localparam logic [2:0] SEL_NONE = 3'd0, SEL_KEY = 3'd1, SEL_NRT = 3'd2,
                           SEL_MSG  = 3'd3, SEL_RES = 3'd4;
    localparam logic [2:0] SEG_E = 3'd0, SEG_N = 3'd1, SEG_R = 3'd2,
                           SEG_T = 3'd3, SEG_NP = 3'd4, SEG_M = 3'd5;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD_KEY  = 4'd1,
        ST_DECRYPT   = 4'd2,
        ST_DRAIN     = 4'd3,
        ST_LOAD_OPS  = 4'd4,
        ST_LOAD_MSG  = 4'd5,
        ST_COMPUTE   = 4'd6,
        ST_SEND      = 4'd7,
        ST_WAIT_NEXT = 4'd8
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   aes_cnt;
    logic [WORD_W-1:0]  key_buf [KEY_WORDS];
    logic [AES_LAT-1:0] aes_sr;
    logic [KI_W-1:0]    kidx;
    logic [KI_W-1:0]    kidx1;
    logic [2:0]         op_seg;
    logic               abort_now;

    assign state_dbg = state;
    assign busy      = (state != ST_IDLE) && (state != ST_WAIT_NEXT);
    assign kidx      = cnt[KI_W-1:0];
    assign kidx1     = kidx | KI_W'(1);

    always_comb begin
        op_seg = SEG_NP;
        if (cnt < CNT_W'(OP_WORDS))
            op_seg = SEG_N;
        else if (cnt < CNT_W'(2 * OP_WORDS))
            op_seg = SEG_R;
        else if (cnt < CNT_W'(3 * OP_WORDS))
            op_seg = SEG_T;
    end

`ifdef MFE_SEQ_TIMEOUT_EN
    // Watchdog: any state that is not waiting on an external party counts as progress.
    logic [15:0] idle_cnt;
    logic        progress;
    logic        timeout;

    always_comb begin
        progress = 1'b1;
        case (state)
            ST_LOAD_KEY, ST_LOAD_OPS, ST_LOAD_MSG: progress = spi_valid;
            ST_COMPUTE:                            progress = mx_done;
            ST_SEND:                               progress = mx_res_valid;
            default:                               progress = 1'b1;
        endcase
    end

    assign timeout   = !progress && (idle_cnt == 16'hFFFF);
    assign abort_now = (abort || timeout) && (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= '0;
        else if (progress || abort_now)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 16'd1;
    end
`else
    assign abort_now = abort && (state != ST_IDLE);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            aes_cnt      <= '0;
            aes_sr       <= '0;
            spi_sel      <= SEL_NONE;
            aes_in       <= '0;
            aes_in_valid <= 1'b0;
            mx_data      <= '0;
            mx_valid     <= 1'b0;
            mx_seg       <= SEG_E;
            mx_start     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            err          <= 1'b0;
            for (int i = 0; i < KEY_WORDS; i++)
                key_buf[i] <= '0;
        end else if (abort_now) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            aes_cnt      <= '0;
            aes_sr       <= '0;
            spi_sel      <= SEL_NONE;
            aes_in       <= '0;
            aes_in_valid <= 1'b0;
            mx_data      <= '0;
            mx_valid     <= 1'b0;
            mx_seg       <= SEG_E;
            mx_start     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            err          <= 1'b1;
        end else begin
            aes_in       <= '0;
            aes_in_valid <= 1'b0;
            mx_valid     <= 1'b0;
            mx_start     <= 1'b0;
            out_valid    <= 1'b0;

            // Valid marker travels alongside the AES core so its output is sampled exactly AES_LAT later.
            aes_sr[0] <= aes_in_valid;
            for (int k = 1; k < AES_LAT; k++)
                aes_sr[k] <= aes_sr[k-1];

            if ((state == ST_DECRYPT || state == ST_DRAIN) && aes_sr[AES_LAT-1] &&
                (aes_cnt != CNT_W'(BLOCKS))) begin
                mx_data  <= aes_out;
                mx_seg   <= SEG_E;
                mx_valid <= 1'b1;
                aes_cnt  <= aes_cnt + CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_LOAD_KEY;
                        spi_sel <= SEL_KEY;
                        err     <= 1'b0;
                        cnt     <= '0;
                        aes_cnt <= '0;
                    end
                end
                ST_LOAD_KEY: begin
                    if (spi_valid) begin
                        key_buf[kidx] <= spi_data;
                        if (cnt == CNT_W'(KEY_WORDS - 1)) begin
                            cnt     <= '0;
                            state   <= ST_DECRYPT;
                            spi_sel <= SEL_NONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DECRYPT: begin
                    aes_in       <= {key_buf[kidx], key_buf[kidx1]};
                    aes_in_valid <= 1'b1;
                    if (cnt == CNT_W'(KEY_WORDS - 2)) begin
                        cnt   <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        cnt <= cnt + CNT_W'(2);
                    end
                end
                ST_DRAIN: begin
                    if (aes_cnt == CNT_W'(BLOCKS)) begin
                        aes_cnt <= '0;
                        cnt     <= '0;
                        state   <= ST_LOAD_OPS;
                        spi_sel <= SEL_NRT;
                    end
                end
                ST_LOAD_OPS: begin
                    if (spi_valid) begin
                        mx_data  <= {{WORD_W{1'b0}}, spi_data};
                        mx_seg   <= op_seg;
                        mx_valid <= 1'b1;
                        if (cnt == CNT_W'(OPS_TOTAL - 1)) begin
                            cnt     <= '0;
                            state   <= ST_LOAD_MSG;
                            spi_sel <= SEL_MSG;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_LOAD_MSG: begin
                    if (spi_valid) begin
                        mx_data  <= {{WORD_W{1'b0}}, spi_data};
                        mx_seg   <= SEG_M;
                        mx_valid <= 1'b1;
                        if (cnt == CNT_W'(OP_WORDS - 1)) begin
                            cnt      <= '0;
                            mx_start <= 1'b1;
                            state    <= ST_COMPUTE;
                            spi_sel  <= SEL_NONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (mx_done) begin
                        cnt     <= '0;
                        state   <= ST_SEND;
                        spi_sel <= SEL_RES;
                    end
                end
                ST_SEND: begin
                    if (mx_res_valid) begin
                        out_data  <= mx_res;
                        out_valid <= 1'b1;
                        if (cnt == CNT_W'(OP_WORDS - 1)) begin
                            cnt     <= '0;
                            state   <= ST_WAIT_NEXT;
                            spi_sel <= SEL_NONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT_NEXT: begin
                    if (next) begin
                        cnt     <= '0;
                        state   <= ST_LOAD_MSG;
                        spi_sel <= SEL_MSG;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    spi_sel <= SEL_NONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mfe_seq.sv
// tb/tb_mfe_seq.sv - directed self-checking bench for mfe_seq (small configuration)
module tb_mfe_seq;
    logic        clk;
    logic        rst;
    logic        start, next, abort;
    logic        spi_valid;
    logic [7:0]  spi_data;
    logic [2:0]  spi_sel;
    logic [15:0] aes_in;
    logic        aes_in_valid;
    logic [15:0] aes_out;
    logic [15:0] mx_data;
    logic        mx_valid;
    logic [2:0]  mx_seg;
    logic        mx_start;
    logic        mx_done;
    logic        mx_res_valid;
    logic [15:0] mx_res;
    logic        out_valid;
    logic [15:0] out_data;
    logic        busy;
    logic        err;
    logic [3:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    mfe_seq #(
        .WORD_W(8), .KEY_WORDS(4), .AES_LAT(3), .OP_WORDS(2), .NP_WORDS(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .next(next), .abort(abort),
        .spi_valid(spi_valid), .spi_data(spi_data), .spi_sel(spi_sel),
        .aes_in(aes_in), .aes_in_valid(aes_in_valid), .aes_out(aes_out),
        .mx_data(mx_data), .mx_valid(mx_valid), .mx_seg(mx_seg),
        .mx_start(mx_start), .mx_done(mx_done), .mx_res_valid(mx_res_valid),
        .mx_res(mx_res), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .err(err), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_message(input logic [7:0] m0, input logic [7:0] m1,
                               input logic [15:0] r0, input logic [15:0] r1);
        spi_valid = 1'b1; spi_data = m0;
        @(negedge clk);
        spi_data = m1;
        @(negedge clk);
        spi_valid = 1'b0;
        mx_done = 1'b1;
        @(negedge clk);
        mx_done = 1'b0;
        mx_res_valid = 1'b1; mx_res = r0;
        @(negedge clk);
        mx_res = r1;
        @(negedge clk);
        mx_res_valid = 1'b0;
    endtask

    logic [7:0]  key_words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [2:0]  op_segs   [7] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};
    logic [15:0] res_words [2] = '{16'h5555, 16'h6666};

    initial begin
        rst = 1'b1; start = 1'b0; next = 1'b0; abort = 1'b0;
        spi_valid = 1'b0; spi_data = '0; aes_out = '0;
        mx_done = 1'b0; mx_res_valid = 1'b0; mx_res = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_spi_sel", 32'(spi_sel), 32'd0);
        chk("rst_busy_err", 32'({busy, err, mx_valid, out_valid, aes_in_valid}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_hold", 32'(state_dbg), 32'd0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("load_key_state", 32'(state_dbg), 32'd1);
        chk("load_key_sel", 32'(spi_sel), 32'd1);
        chk("load_key_busy", 32'(busy), 32'd1);

        for (int i = 0; i < 4; i++) begin
            spi_valid = 1'b1; spi_data = key_words[i];
            @(negedge clk);
        end
        // fifth key word and a further stray word land while decrypting
        spi_data = 8'h55;
        chk("decrypt_state", 32'(state_dbg), 32'd2);
        chk("decrypt_sel", 32'(spi_sel), 32'd0);
        @(negedge clk);
        spi_data = 8'h66;
        chk("aes_blk0_valid", 32'(aes_in_valid), 32'd1);
        chk("aes_blk0", 32'(aes_in), 32'h1122);
        @(negedge clk);
        spi_valid = 1'b0;
        chk("aes_blk1_valid", 32'(aes_in_valid), 32'd1);
        chk("aes_blk1", 32'(aes_in), 32'h3344);
        chk("drain_state", 32'(state_dbg), 32'd3);
        @(negedge clk);
        chk("aes_idle_after", 32'(aes_in_valid), 32'd0);
        @(negedge clk);
        aes_out = 16'hAAAA;
        @(negedge clk);
        aes_out = 16'hBBBB;
        chk("mx_e0_valid", 32'(mx_valid), 32'd1);
        chk("mx_e0_data", 32'(mx_data), 32'hAAAA);
        chk("mx_e0_seg", 32'(mx_seg), 32'd0);
        @(negedge clk);
        aes_out = 16'h0000;
        chk("mx_e1_valid", 32'(mx_valid), 32'd1);
        chk("mx_e1_data", 32'(mx_data), 32'hBBBB);
        @(negedge clk);
        chk("load_ops_state", 32'(state_dbg), 32'd4);
        chk("load_ops_sel", 32'(spi_sel), 32'd2);

        for (int i = 0; i < 7; i++) begin
            spi_valid = 1'b1; spi_data = 8'(i + 1);
            @(negedge clk);
            chk($sformatf("op%0d_data", i), 32'(mx_data), 32'(i + 1));
            chk($sformatf("op%0d_seg", i), 32'(mx_seg), 32'(op_segs[i]));
        end
        chk("load_msg_state", 32'(state_dbg), 32'd5);
        chk("load_msg_sel", 32'(spi_sel), 32'd3);

        for (int i = 0; i < 2; i++) begin
            spi_valid = 1'b1; spi_data = 8'(8 + i);
            @(negedge clk);
            chk($sformatf("msg%0d_data", i), 32'(mx_data), 32'(8 + i));
            chk($sformatf("msg%0d_seg", i), 32'(mx_seg), 32'd5);
        end
        spi_valid = 1'b0;
        chk("mx_start_pulse", 32'(mx_start), 32'd1);
        chk("compute_state", 32'(state_dbg), 32'd6);
        chk("compute_sel", 32'(spi_sel), 32'd0);
        mx_res_valid = 1'b1; mx_res = 16'hDEAD;
        @(negedge clk);
        mx_res_valid = 1'b0;
        chk("mx_start_single", 32'(mx_start), 32'd0);
        chk("res_ignored", 32'(out_valid), 32'd0);

        mx_done = 1'b1;
        @(negedge clk);
        mx_done = 1'b0;
        chk("send_state", 32'(state_dbg), 32'd7);
        chk("send_sel", 32'(spi_sel), 32'd4);
        for (int i = 0; i < 2; i++) begin
            mx_res_valid = 1'b1; mx_res = res_words[i];
            @(negedge clk);
            chk($sformatf("res%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("res%0d_data", i), 32'(out_data), 32'(res_words[i]));
        end
        mx_res_valid = 1'b0;
        chk("wait_state", 32'(state_dbg), 32'd8);
        chk("wait_sel", 32'(spi_sel), 32'd0);
        chk("wait_busy", 32'(busy), 32'd0);

        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        chk("next_state", 32'(state_dbg), 32'd5);
        chk("next_sel", 32'(spi_sel), 32'd3);

        run_message(8'h0A, 8'h0B, 16'h1234, 16'h5678);
        chk("wait2_state", 32'(state_dbg), 32'd8);
        chk("wait2_out", 32'(out_data), 32'h5678);

        abort = 1'b1; next = 1'b1;
        @(negedge clk);
        abort = 1'b0; next = 1'b0;
        chk("abort_state", 32'(state_dbg), 32'd0);
        chk("abort_err", 32'(err), 32'd1);
        chk("abort_outputs", 32'({spi_sel, busy, mx_valid, out_valid}), 32'd0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_state", 32'(state_dbg), 32'd1);
        chk("restart_err", 32'(err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            spi_valid = 1'b1; spi_data = key_words[i];
            @(negedge clk);
        end
        spi_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_aes_valid", 32'(aes_in_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_state", 32'(state_dbg), 32'd0);
        chk("rst_mid_aes", 32'({aes_in_valid, aes_in}), 32'd0);
        chk("rst_mid_outputs", 32'({spi_sel, busy, err, mx_valid, out_valid, mx_start}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        next = 1'b1;
        repeat (3) @(negedge clk);
        next = 1'b0;
        chk("post_rst_no_start", 32'(state_dbg), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
